// File: rtl/fp_single_divider.sv
// fp_single_divider: multi-cycle binary16 divider, z = a / b.
//
// Restoring division develops one quotient bit per cycle. The result is rounded to
// nearest-even and fully handles subnormals, zeros, infinities and NaNs.
// The handshake matches fp_single_multiplier, so either unit can sit behind
// the same controller.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   start    - request, sampled only while idle
//   input_a  - dividend (binary16)
//   input_b  - divisor (binary16)
//   output_z - quotient (binary16), held until the next result
//   ack      - one-cycle pulse, operands accepted
//   done     - one-cycle pulse, output_z valid this cycle
//   busy     - high from acceptance until done inclusive
module fp_single_divider #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned EXP_BITS = 5,
    parameter int unsigned MAN_BITS = 10,
    parameter int unsigned QBITS    = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH-1:0] output_z,
    output logic             ack,
    output logic             done,
    output logic             busy
);

    localparam int unsigned SIG = MAN_BITS + 1;  // significand incl. hidden bit
    localparam int unsigned REM = SIG + 1;       // partial remainder width

    localparam logic [EXP_BITS-1:0] EXP_ONES = {EXP_BITS{1'b1}};
    localparam logic [MAN_BITS-1:0] MAN_ZERO = {MAN_BITS{1'b0}};
    localparam logic [WIDTH-1:0]    QNAN     =
        {1'b0, EXP_ONES, 1'b1, {(MAN_BITS-1){1'b0}}};
    localparam logic signed [7:0]   SHIFT_SAT = 8'sd13;

    typedef enum logic [2:0] {
        StIdle, StUnpack, StSpecial, StDivide, StNorm, StRound, StPack
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]      a_q, b_q;
    logic                  sign_q;
    logic signed [7:0]     exp_a_q, exp_b_q, exp_q;
    logic [SIG-1:0]        man_a_q, man_b_q;
    logic [REM-1:0]        rem_q;
    logic [QBITS-1:0]      quot_q;
    logic [3:0]            count_q;
    logic                  sticky_q;
    logic [MAN_BITS-1:0]   man_q;
    logic                  spec_q;
    logic [WIDTH-1:0]      spec_z_q;
    logic [WIDTH-1:0]      z_q;
    logic                  done_q;

    // Distance to shift a significand left so its top bit is set.
    function automatic logic [3:0] lead_shift(input logic [SIG-1:0] m);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < SIG; i++) begin
            if (m[i]) s = 4'(SIG - 1 - i);
        end
        return s;
    endfunction

    // ---------------------------------------------------------------- classification
    logic [EXP_BITS-1:0] a_exp, b_exp;
    logic [MAN_BITS-1:0] a_man, b_man;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    always_comb begin
        a_exp  = a_q[WIDTH-2 -: EXP_BITS];
        b_exp  = b_q[WIDTH-2 -: EXP_BITS];
        a_man  = a_q[MAN_BITS-1:0];
        b_man  = b_q[MAN_BITS-1:0];
        a_nan  = (&a_exp) & (|a_man);
        a_inf  = (&a_exp) & ~(|a_man);
        a_zero = ~(|a_exp) & ~(|a_man);
        b_nan  = (&b_exp) & (|b_man);
        b_inf  = (&b_exp) & ~(|b_man);
        b_zero = ~(|b_exp) & ~(|b_man);
    end

    // ---------------------------------------------------------------- unpack
    logic [SIG-1:0]    a_sig, b_sig, a_norm, b_norm;
    logic [3:0]        a_shift, b_shift;
    logic signed [7:0] a_unb, b_unb, a_adj, b_adj;

    always_comb begin
        // Subnormals carry exponent -14 and no hidden bit, then get normalised.
        a_sig   = {|a_exp, a_man};
        b_sig   = {|b_exp, b_man};
        a_shift = lead_shift(a_sig);
        b_shift = lead_shift(b_sig);
        a_norm  = a_sig << a_shift;
        b_norm  = b_sig << b_shift;
        a_unb   = (|a_exp) ? $signed(8'(a_exp)) - 8'sd15 : -8'sd14;
        b_unb   = (|b_exp) ? $signed(8'(b_exp)) - 8'sd15 : -8'sd14;
        a_adj   = a_unb - $signed({4'b0000, a_shift});
        b_adj   = b_unb - $signed({4'b0000, b_shift});
    end

    // ---------------------------------------------------------------- special cases
    logic             spec_hit;
    logic [WIDTH-1:0] spec_val;

    always_comb begin
        spec_hit = 1'b1;
        spec_val = QNAN;
        if (a_nan | b_nan) begin
            spec_val = QNAN;
        end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
            spec_val = QNAN;
        end else if (a_inf | b_zero) begin
            spec_val = {sign_q, EXP_ONES, MAN_ZERO};
        end else if (a_zero | b_inf) begin
            spec_val = {sign_q, {(WIDTH-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ---------------------------------------------------------------- divide step
    logic           rem_ge;
    logic [REM-1:0] rem_sub, rem_d;

    always_comb begin
        rem_ge  = rem_q >= {1'b0, man_b_q};
        rem_sub = rem_ge ? rem_q - {1'b0, man_b_q} : rem_q;
        // rem_sub < divisor, so the shift never drops a set bit
        rem_d   = rem_sub << 1;
    end

    // ---------------------------------------------------------------- normalise
    logic [QBITS-1:0]  nq_shifted, nq_final;
    logic signed [7:0] ne, ne_final, n_dist;
    logic [3:0]        n_sh;
    logic              n_lost;

    always_comb begin
        nq_shifted = quot_q[QBITS-1] ? quot_q : quot_q << 1;
        ne         = quot_q[QBITS-1] ? exp_q : exp_q - 8'sd1;
        n_dist     = 8'sd1 - ne;
        n_sh       = '0;
        n_lost     = 1'b0;
        nq_final   = nq_shifted;
        ne_final   = ne;
        if (ne < 8'sd1) begin
            // Denormalise into the subnormal range; lost bits feed sticky.
            n_sh     = (n_dist > SHIFT_SAT) ? SHIFT_SAT[3:0] : n_dist[3:0];
            n_lost   = |(nq_shifted & ~({QBITS{1'b1}} << n_sh));
            nq_final = nq_shifted >> n_sh;
            ne_final = 8'sd0;
        end
    end

    // ---------------------------------------------------------------- round
    logic              r_up, r_sticky;
    logic [SIG:0]      r_sum;
    logic [MAN_BITS-1:0] r_man;
    logic signed [7:0] r_exp;

    always_comb begin
        // quot_q = {significand[10:0], guard, round, sticky}
        r_sticky = quot_q[0] | sticky_q | (|rem_q);
        r_up     = quot_q[2] & (quot_q[1] | r_sticky | quot_q[3]);
        r_sum    = {1'b0, quot_q[QBITS-1 -: SIG]} + {{SIG{1'b0}}, r_up};
        if (r_sum[SIG]) begin
            r_man = r_sum[MAN_BITS:1];
            r_exp = exp_q + 8'sd1;
        end else begin
            r_man = r_sum[MAN_BITS-1:0];
            // A subnormal that rounds up into the hidden bit becomes normal.
            r_exp = (exp_q == 8'sd0 && r_sum[MAN_BITS]) ? 8'sd1 : exp_q;
        end
    end

    // ---------------------------------------------------------------- pack
    logic [WIDTH-1:0] z_pack;

    always_comb begin
        if (spec_q) begin
            z_pack = spec_z_q;
        end else if (exp_q >= 8'sd31) begin
            z_pack = {sign_q, EXP_ONES, MAN_ZERO};
        end else begin
            z_pack = {sign_q, exp_q[EXP_BITS-1:0], man_q};
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StUnpack;
            StUnpack:  state_d = StSpecial;
            StSpecial: state_d = spec_hit ? StPack : StDivide;
            StDivide:  if (count_q == 4'(QBITS - 1)) state_d = StNorm;
            StNorm:    state_d = StRound;
            StRound:   state_d = StPack;
            StPack:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        ack      = (state_q == StUnpack);
        busy     = (state_q != StIdle) | done_q;
        done     = done_q;
        output_z = z_q;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_a_q  <= '0;
            exp_b_q  <= '0;
            exp_q    <= '0;
            man_a_q  <= '0;
            man_b_q  <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
            man_q    <= '0;
            spec_q   <= 1'b0;
            spec_z_q <= '0;
            z_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q <= input_a;
                        b_q <= input_b;
                    end
                end
                StUnpack: begin
                    sign_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    exp_a_q <= a_adj;
                    exp_b_q <= b_adj;
                    man_a_q <= a_norm;
                    man_b_q <= b_norm;
                end
                StSpecial: begin
                    spec_q   <= spec_hit;
                    spec_z_q <= spec_val;
                    exp_q    <= exp_a_q - exp_b_q + 8'sd15;
                    rem_q    <= {1'b0, man_a_q};
                    quot_q   <= '0;
                    count_q  <= '0;
                    sticky_q <= 1'b0;
                end
                StDivide: begin
                    rem_q   <= rem_d;
                    quot_q  <= {quot_q[QBITS-2:0], rem_ge};
                    count_q <= count_q + 4'd1;
                end
                StNorm: begin
                    quot_q   <= nq_final;
                    exp_q    <= ne_final;
                    sticky_q <= sticky_q | n_lost;
                end
                StRound: begin
                    exp_q <= r_exp;
                    man_q <= r_man;
                end
                StPack: begin
                    z_q    <= z_pack;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
